// File: rtl/spi_image_rx.sv
// spi_image_rx: SPI-slave (mode 0) receiver for one binarised 30x30 image frame.
// Bytes arrive MSB first on mosi and are written to the image buffer one byte per
// write_enable pulse. Each frame opens with a one-cycle clear_buffer pulse and
// closes with a frame_done pulse carrying the frame_ok / frame_err verdict.
// The previous frame's status byte is shifted back out on miso during the next frame.
// SYNC_STAGES must be at least 2.
module spi_image_rx #(
  parameter int FRAME_BYTES = 113,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       clear_buffer,
  output logic [7:0] data_out,
  output logic       write_enable,
  output logic [6:0] byte_count,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam int                 FLUSH_W       = $clog2(SYNC_STAGES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE    = FLUSH_W'(SYNC_STAGES);
  localparam logic [6:0]         FRAME_BYTES_C = 7'(FRAME_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Status byte returned to the host: {ok, err, overflow, 5'b0}.
  function automatic logic [7:0] status_byte(input logic ok, input logic err, input logic ovf);
    return {ok, err, ovf, 5'b00000};
  endfunction

  // Synchroniser chains and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   sclk_d_r;
  logic                   cs_d_r;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;
  logic                   cs_rise_s;

  // Arming: the cs_n chain resets high, so it must be flushed with real pin
  // samples before a high cs_n is trusted; otherwise a reset released in the
  // middle of a transfer would arm immediately and start a misaligned frame.
  logic [FLUSH_W-1:0] flush_cnt_r;
  logic               armed_r;

  // FSM and datapath state
  state_t     state_r;
  state_t     state_next_s;
  logic [2:0] bit_cnt_r,     bit_cnt_next_s;
  logic [7:0] shift_r,       shift_next_s;
  logic [7:0] miso_sr_r,     miso_sr_next_s;
  logic       overflow_r,    overflow_next_s;
  logic [7:0] data_out_r,    data_out_next_s;
  logic [6:0] byte_count_r,  byte_count_next_s;
  logic       busy_r,        busy_next_s;
  logic       frame_ok_r,    frame_ok_next_s;
  logic       frame_err_r,   frame_err_next_s;
  logic       clear_r,       clear_next_s;
  logic       we_r,          we_next_s;
  logic       done_r,        done_next_s;
  logic       frame_good_s;
  logic [7:0] shifted_byte_s;

  // Bring sclk, mosi and cs_n into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      mosi_sync_r <= '0;
      cs_sync_r   <= '1;
      sclk_d_r    <= 1'b0;
      cs_d_r      <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
      cs_d_r      <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_s & sclk_d_r;
  assign cs_rise_s   = cs_s & ~cs_d_r;

  // Arm once a genuinely synchronised cs_n high has been seen after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_r <= '0;
      armed_r     <= 1'b0;
    end else begin
      if (flush_cnt_r != FLUSH_DONE) begin
        flush_cnt_r <= flush_cnt_r + FLUSH_W'(1);
      end
      if ((flush_cnt_r == FLUSH_DONE) && cs_s) begin
        armed_r <= 1'b1;
      end
    end
  end

  assign frame_good_s   = (byte_count_r == FRAME_BYTES_C) && !overflow_r && (bit_cnt_r == 3'd0);
  assign shifted_byte_s = {shift_r[6:0], mosi_s};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and next-value logic for the receive FSM
  always_comb begin
    state_next_s      = state_r;
    bit_cnt_next_s    = bit_cnt_r;
    shift_next_s      = shift_r;
    miso_sr_next_s    = miso_sr_r;
    overflow_next_s   = overflow_r;
    data_out_next_s   = data_out_r;
    byte_count_next_s = byte_count_r;
    busy_next_s       = busy_r;
    frame_ok_next_s   = frame_ok_r;
    frame_err_next_s  = frame_err_r;
    clear_next_s      = 1'b0;
    we_next_s         = 1'b0;
    done_next_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (!cs_s && armed_r) begin
          clear_next_s      = 1'b1;
          bit_cnt_next_s    = 3'd0;
          byte_count_next_s = 7'd0;
          overflow_next_s   = 1'b0;
          frame_ok_next_s   = 1'b0;
          frame_err_next_s  = 1'b0;
          miso_sr_next_s    = status_byte(frame_ok_r, frame_err_r, overflow_r);
          busy_next_s       = 1'b1;
          state_next_s      = ST_RECV;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_RECV: begin
        if (cs_rise_s) begin
          // End of frame wins over a coincident sclk edge; partial byte dropped.
          state_next_s = ST_DONE;
        end else if (sclk_rise_s) begin
          shift_next_s   = shifted_byte_s;
          bit_cnt_next_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            data_out_next_s = shifted_byte_s;
            if (byte_count_r < FRAME_BYTES_C) begin
              we_next_s         = 1'b1;
              byte_count_next_s = byte_count_r + 7'd1;
            end else begin
              overflow_next_s   = 1'b1;
              byte_count_next_s = FRAME_BYTES_C;
            end
          end else begin
            data_out_next_s = data_out_r;
          end
        end else if (sclk_fall_s) begin
          miso_sr_next_s = {miso_sr_r[6:0], 1'b0};
        end else begin
          state_next_s = ST_RECV;
        end
      end

      ST_DONE: begin
        done_next_s      = 1'b1;
        busy_next_s      = 1'b0;
        frame_ok_next_s  = frame_good_s;
        frame_err_next_s = !frame_good_s;
        state_next_s     = ST_IDLE;
      end

      default: begin
        state_next_s = ST_IDLE;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // Datapath and registered output state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      miso_sr_r    <= 8'h00;
      overflow_r   <= 1'b0;
      data_out_r   <= 8'h00;
      byte_count_r <= 7'd0;
      busy_r       <= 1'b0;
      frame_ok_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      clear_r      <= 1'b0;
      we_r         <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      bit_cnt_r    <= bit_cnt_next_s;
      shift_r      <= shift_next_s;
      miso_sr_r    <= miso_sr_next_s;
      overflow_r   <= overflow_next_s;
      data_out_r   <= data_out_next_s;
      byte_count_r <= byte_count_next_s;
      busy_r       <= busy_next_s;
      frame_ok_r   <= frame_ok_next_s;
      frame_err_r  <= frame_err_next_s;
      clear_r      <= clear_next_s;
      we_r         <= we_next_s;
      done_r       <= done_next_s;
    end
  end

  assign miso         = miso_sr_r[7];
  assign clear_buffer = clear_r;
  assign data_out     = data_out_r;
  assign write_enable = we_r;
  assign byte_count   = byte_count_r;
  assign busy         = busy_r;
  assign frame_done   = done_r;
  assign frame_ok     = frame_ok_r;
  assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_spi_image_rx.sv
// Directed testbench for spi_image_rx: nominal, overflow, short/partial,
// reset mid-frame, cs/sclk edge collision and back-to-back status readback.
module tb_spi_image_rx;

  localparam int HALF = 4;  // sclk half period in clk cycles (sclk = clk/8)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;
  logic       clear_buffer;
  logic [7:0] data_out;
  logic       write_enable;
  logic [6:0] byte_count;
  logic       busy;
  logic       frame_done;
  logic       frame_ok;
  logic       frame_err;

  int tests = 0;
  int fails = 0;

  int         we_cnt = 0;
  int         clr_cnt = 0;
  int         done_cnt = 0;
  int         clr_we_snap = 0;
  logic       last_ok = 1'b0;
  logic       last_err = 1'b0;
  logic [7:0] wr_log [0:1023];
  logic [7:0] rx_byte = 8'h00;

  spi_image_rx #(.FRAME_BYTES(113), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .mosi         (mosi),
    .cs_n         (cs_n),
    .miso         (miso),
    .clear_buffer (clear_buffer),
    .data_out     (data_out),
    .write_enable (write_enable),
    .byte_count   (byte_count),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive clock edge
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      wr_log[we_cnt % 1024] = data_out;
      we_cnt = we_cnt + 1;
    end
    if (clear_buffer === 1'b1) begin
      clr_cnt = clr_cnt + 1;
      clr_we_snap = we_cnt;
    end
    if (frame_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      last_ok = frame_ok;
      last_err = frame_err;
    end
  end

  // Watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Clock n bits of b out MSB first; miso is captured on each sclk rise
  task automatic spi_bits(input logic [7:0] b, input int n);
    rx_byte = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      wait_clks(HALF);
      sclk = 1'b1;
      rx_byte = {rx_byte[6:0], miso};
      wait_clks(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  // Raise cs_n (optionally together with sclk) and wait a bounded time for frame_done
  task automatic frame_end(input string name, input logic with_sclk);
    int d0;
    wait_clks(HALF);
    d0 = done_cnt;
    cs_n = 1'b1;
    if (with_sclk) sclk = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_clks(1);
      if (done_cnt != d0) break;
    end
    sclk = 1'b0;
    tests++;
    if (done_cnt != d0 + 1) begin
      fails++;
      $display("FAIL %s_frame_done: got %0d pulses, required 1", name, done_cnt - d0);
    end
    wait_clks(6);
  endtask

  task automatic send_frame(input string name, input logic [7:0] start, input int n,
                            output logic [7:0] status);
    status = 8'h00;
    frame_begin();
    for (int i = 0; i < n; i++) begin
      spi_bits(start + 8'(i), 8);
      if (i == 0) status = rx_byte;
    end
    frame_end(name, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clks(3);
    tests++;
    if ({clear_buffer, write_enable, frame_done, busy, frame_ok, frame_err, miso} !== 7'b0000000) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 0000000",
               {clear_buffer, write_enable, frame_done, busy, frame_ok, frame_err, miso});
    end
    tests++;
    if ({data_out, byte_count} !== 15'h0000) begin
      fails++;
      $display("FAIL reset_data: got data_out=%h byte_count=%0d, required 00 and 0", data_out, byte_count);
    end
    rst_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic test_nominal();
    int w0, c0;
    logic [7:0] st;
    w0 = we_cnt;
    c0 = clr_cnt;
    send_frame("nominal", 8'h00, 113, st);
    tests++;
    if (we_cnt - w0 != 113) begin
      fails++; $display("FAIL nominal_writes: got %0d, required 113", we_cnt - w0);
    end
    for (int i = 0; i < 113; i++) begin
      tests++;
      if (wr_log[(w0 + i) % 1024] !== 8'(i)) begin
        fails++; $display("FAIL nominal_data[%0d]: got %h, required %h", i, wr_log[(w0 + i) % 1024], 8'(i));
      end
    end
    tests++;
    if (byte_count !== 7'd113) begin
      fails++; $display("FAIL nominal_count: got %0d, required 113", byte_count);
    end
    tests++;
    if ({last_ok, last_err} !== 2'b10) begin
      fails++; $display("FAIL nominal_status: got ok=%b err=%b, required ok=1 err=0", last_ok, last_err);
    end
    tests++;
    if (clr_cnt - c0 != 1 || clr_we_snap != w0) begin
      fails++; $display("FAIL nominal_clear: got %0d clears with %0d writes before, required 1 and 0",
                        clr_cnt - c0, clr_we_snap - w0);
    end
    tests++;
    if (st !== 8'h00) begin
      fails++; $display("FAIL nominal_miso: got %h, required 00", st);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL nominal_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_overflow();
    int w0;
    logic [7:0] st;
    w0 = we_cnt;
    send_frame("overflow", 8'h00, 115, st);
    tests++;
    if (we_cnt - w0 != 113) begin
      fails++; $display("FAIL overflow_writes: got %0d, required 113", we_cnt - w0);
    end
    tests++;
    if (data_out !== 8'h72) begin
      fails++; $display("FAIL overflow_data_out: got %h, required 72", data_out);
    end
    tests++;
    if (byte_count !== 7'd113) begin
      fails++; $display("FAIL overflow_count: got %0d, required 113", byte_count);
    end
    tests++;
    if ({last_ok, last_err} !== 2'b01) begin
      fails++; $display("FAIL overflow_status: got ok=%b err=%b, required ok=0 err=1", last_ok, last_err);
    end
    tests++;
    if (st !== 8'h80) begin
      fails++; $display("FAIL overflow_miso: got %h, required 80", st);
    end
  endtask

  task automatic test_short();
    int w0;
    logic [7:0] st;
    w0 = we_cnt;
    st = 8'h00;
    frame_begin();
    for (int i = 0; i < 50; i++) begin
      spi_bits(8'h20 + 8'(i), 8);
      if (i == 0) st = rx_byte;
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL short_busy: got %b, required 1", busy);
    end
    spi_bits(8'hA5, 3);
    frame_end("short", 1'b0);
    tests++;
    if (we_cnt - w0 != 50) begin
      fails++; $display("FAIL short_writes: got %0d, required 50", we_cnt - w0);
    end
    tests++;
    if (byte_count !== 7'd50) begin
      fails++; $display("FAIL short_count: got %0d, required 50", byte_count);
    end
    tests++;
    if ({last_ok, last_err} !== 2'b01) begin
      fails++; $display("FAIL short_status: got ok=%b err=%b, required ok=0 err=1", last_ok, last_err);
    end
    tests++;
    if (st !== 8'h60) begin
      fails++; $display("FAIL short_miso: got %h, required 60", st);
    end
  endtask

  task automatic test_reset_mid_frame();
    int w0, c0, d0, w1;
    logic [7:0] st;
    frame_begin();
    for (int i = 0; i < 19; i++) spi_bits(8'h40 + 8'(i), 8);
    spi_bits(8'hFF, 4);
    w0 = we_cnt;
    c0 = clr_cnt;
    d0 = done_cnt;
    rst_n = 1'b0;
    wait_clks(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) spi_bits(8'h90 + 8'(i), 8);
    tests++;
    if (we_cnt != w0 || clr_cnt != c0 || done_cnt != d0) begin
      fails++; $display("FAIL rstmid_pulses: got writes=%0d clears=%0d dones=%0d, required 0 0 0",
                        we_cnt - w0, clr_cnt - c0, done_cnt - d0);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_busy: got %b, required 0", busy);
    end
    cs_n = 1'b1;
    wait_clks(8);
    w1 = we_cnt;
    send_frame("rstmid", 8'h05, 113, st);
    tests++;
    if (we_cnt - w1 != 113) begin
      fails++; $display("FAIL rstmid_writes: got %0d, required 113", we_cnt - w1);
    end
    tests++;
    if ({last_ok, last_err} !== 2'b10) begin
      fails++; $display("FAIL rstmid_status: got ok=%b err=%b, required ok=1 err=0", last_ok, last_err);
    end
    tests++;
    if (st !== 8'h00) begin
      fails++; $display("FAIL rstmid_miso: got %h, required 00", st);
    end
  endtask

  task automatic test_collision();
    logic [7:0] st;
    st = 8'h00;
    frame_begin();
    for (int i = 0; i < 113; i++) begin
      spi_bits(8'hFF - 8'(i), 8);
      if (i == 0) st = rx_byte;
    end
    mosi = 1'b1;
    frame_end("collision", 1'b1);
    tests++;
    if ({last_ok, last_err} !== 2'b10) begin
      fails++; $display("FAIL collision_status: got ok=%b err=%b, required ok=1 err=0", last_ok, last_err);
    end
    tests++;
    if (byte_count !== 7'd113) begin
      fails++; $display("FAIL collision_count: got %0d, required 113", byte_count);
    end
    tests++;
    if (st !== 8'h80) begin
      fails++; $display("FAIL collision_miso: got %h, required 80", st);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    logic [7:0] st;
    send_frame("b2b_one", 8'h55, 1, st);
    tests++;
    if (st !== 8'h80) begin
      fails++; $display("FAIL b2b_miso_after_ok: got %h, required 80", st);
    end
    tests++;
    if ({last_ok, last_err} !== 2'b01) begin
      fails++; $display("FAIL b2b_one_status: got ok=%b err=%b, required ok=0 err=1", last_ok, last_err);
    end
    w0 = we_cnt;
    frame_begin();
    frame_end("b2b_zero", 1'b0);
    tests++;
    if (byte_count !== 7'd0 || we_cnt != w0) begin
      fails++; $display("FAIL zero_count: got count=%0d writes=%0d, required 0 0", byte_count, we_cnt - w0);
    end
    tests++;
    if ({last_ok, last_err} !== 2'b01) begin
      fails++; $display("FAIL zero_status: got ok=%b err=%b, required ok=0 err=1", last_ok, last_err);
    end
    send_frame("b2b_two", 8'h66, 2, st);
    tests++;
    if (st !== 8'h40) begin
      fails++; $display("FAIL b2b_miso_after_err: got %h, required 40", st);
    end
    tests++;
    if (wr_log[(we_cnt - 1) % 1024] !== 8'h67 || byte_count !== 7'd2) begin
      fails++; $display("FAIL b2b_two_data: got %h count=%0d, required 67 count=2",
                        wr_log[(we_cnt - 1) % 1024], byte_count);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overflow();
    test_short();
    test_reset_mid_frame();
    test_collision();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
